// File: rtl/dmem_rr_arbiter_pkg.sv
// Shared types for the data-memory round-robin arbiter.
// Arbiter FSM states and memory-side request/response bundles.
package dmem_rr_arbiter_pkg;

    localparam int dmem_addr_width_lp = 32;
    localparam int dmem_data_width_lp = 32;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT
    } arb_state_e;

    typedef struct packed {
        logic                          valid;
        logic                          we;
        logic [dmem_addr_width_lp-1:0] addr;
        logic [dmem_data_width_lp-1:0] wdata;
    } mem_in_s;

    typedef struct packed {
        logic                          valid;
        logic [dmem_data_width_lp-1:0] rdata;
    } mem_out_s;

endpackage

// File: rtl/dmem_rr_arbiter_if.sv
// Core-side and memory-side bus of the data-memory arbiter.
// slave is the arbiter view, master is the cores/memory view.
interface dmem_rr_arbiter_if #(
    parameter int num_cores_p  = 4,
    parameter int addr_width_p = 32,
    parameter int data_width_p = 32
) ();

    logic [num_cores_p-1:0]              req_valid_i;
    logic [num_cores_p-1:0]              req_we_i;
    logic [num_cores_p*addr_width_p-1:0] req_addr_i;
    logic [num_cores_p*data_width_p-1:0] req_wdata_i;
    logic [num_cores_p-1:0]              req_ready_o;
    logic [num_cores_p-1:0]              resp_valid_o;
    logic [data_width_p-1:0]             resp_data_o;
    logic                                mem_valid_o;
    logic                                mem_we_o;
    logic [addr_width_p-1:0]             mem_addr_o;
    logic [data_width_p-1:0]             mem_wdata_o;
    logic                                mem_ready_i;
    logic                                mem_resp_valid_i;
    logic [data_width_p-1:0]             mem_rdata_i;

    modport slave (
        input  req_valid_i, req_we_i, req_addr_i, req_wdata_i,
        input  mem_ready_i, mem_resp_valid_i, mem_rdata_i,
        output req_ready_o, resp_valid_o, resp_data_o,
        output mem_valid_o, mem_we_o, mem_addr_o, mem_wdata_o
    );

    modport master (
        output req_valid_i, req_we_i, req_addr_i, req_wdata_i,
        output mem_ready_i, mem_resp_valid_i, mem_rdata_i,
        input  req_ready_o, resp_valid_o, resp_data_o,
        input  mem_valid_o, mem_we_o, mem_addr_o, mem_wdata_o
    );

endinterface

// File: rtl/dmem_rr_arbiter_picker.sv
// Round-robin priority picker: first requester at or after ptr_i.
// Combinational; yields a one-hot grant and its index.
module rr_priority_picker #(
    parameter int num_req_p = 4
) (
    input  logic [num_req_p-1:0]         req_i,
    input  logic [$clog2(num_req_p)-1:0] ptr_i,
    output logic [num_req_p-1:0]         grant_o,
    output logic [$clog2(num_req_p)-1:0] idx_o,
    output logic                         any_o
);

    localparam int iw_lp = $clog2(num_req_p);

    // Scan from the pointer with wraparound; the first hit wins
    always_comb begin
        logic             found;
        logic [iw_lp-1:0] k;
        grant_o = '0;
        idx_o   = '0;
        found   = 1'b0;
        k       = '0;
        for (int i = 0; i < num_req_p; i++) begin
            k = iw_lp'((int'(ptr_i) + i) % num_req_p);
            if (!found && req_i[k]) begin
                found      = 1'b1;
                grant_o[k] = 1'b1;
                idx_o      = k;
            end
        end
    end

    assign any_o = |req_i;

endmodule

// File: rtl/dmem_rr_arbiter.sv
// Round-robin arbiter sharing one data-memory port among cores.
// One transaction in flight; a watchdog aborts reads that never return.
module dmem_rr_arbiter
    import dmem_rr_arbiter_pkg::*;
#(
    parameter int num_cores_p  = 4,
    parameter int addr_width_p = 32,
    parameter int data_width_p = 32,
    parameter int timeout_p    = 255
) (
    input  logic                           clk,
    input  logic                           reset,
    dmem_rr_arbiter_if.slave               bus,
    output logic                           timeout_o,
    output logic [$clog2(num_cores_p)-1:0] grant_id_o
);

    localparam int          iw_lp       = $clog2(num_cores_p);
    localparam logic [15:0] last_cnt_lp = 16'(timeout_p - 1);

    arb_state_e state_q, state_d;

    logic [iw_lp-1:0]        ptr_q, grant_id_q, pick_idx;
    logic [num_cores_p-1:0]  pick_oh, grant_oh_q, resp_valid_q;
    logic                    pick_any, grant_en, accept;
    logic                    resp_hit, expire, timeout_q, we_q;
    logic [15:0]             cnt_q;
    logic [addr_width_p-1:0] addr_q;
    logic [data_width_p-1:0] wdata_q, rdata_q;
    logic [addr_width_p-1:0] addr_a  [num_cores_p];
    logic [data_width_p-1:0] wdata_a [num_cores_p];

    for (genvar k = 0; k < num_cores_p; k++) begin : g_unpack
        assign addr_a[k]  = bus.req_addr_i[k*addr_width_p +: addr_width_p];
        assign wdata_a[k] = bus.req_wdata_i[k*data_width_p +: data_width_p];
    end

    rr_priority_picker #(
        .num_req_p(num_cores_p)
    ) u_picker (
        .req_i  (bus.req_valid_i),
        .ptr_i  (ptr_q),
        .grant_o(pick_oh),
        .idx_o  (pick_idx),
        .any_o  (pick_any)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next state; a response beats a watchdog expiry in the same cycle
    always_comb begin
        state_d  = state_q;
        grant_en = 1'b0;
        accept   = 1'b0;
        resp_hit = 1'b0;
        expire   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (pick_any) begin
                    grant_en = 1'b1;
                    state_d  = ISSUE;
                end
            end
            ISSUE: begin
                if (bus.mem_ready_i) begin
                    accept  = 1'b1;
                    state_d = we_q ? IDLE : WAIT;
                end
            end
            WAIT: begin
                if (bus.mem_resp_valid_i) begin
                    resp_hit = 1'b1;
                    state_d  = IDLE;
                end else if (cnt_q == last_cnt_lp) begin
                    expire  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Grant latch, rr pointer, watchdog and registered response
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q        <= '0;
            grant_id_q   <= '0;
            grant_oh_q   <= '0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            cnt_q        <= '0;
            rdata_q      <= '0;
            resp_valid_q <= '0;
            timeout_q    <= 1'b0;
        end else begin
            resp_valid_q <= '0;
            timeout_q    <= 1'b0;
            if (grant_en) begin
                grant_oh_q <= pick_oh;
                grant_id_q <= pick_idx;
                we_q       <= bus.req_we_i[pick_idx];
                addr_q     <= addr_a[pick_idx];
                wdata_q    <= wdata_a[pick_idx];
                ptr_q      <= (pick_idx == iw_lp'(num_cores_p - 1))
                              ? '0 : pick_idx + 1'b1;
            end
            cnt_q <= (state_q == WAIT) ? cnt_q + 16'd1 : 16'd0;
            if (resp_hit) begin
                rdata_q      <= bus.mem_rdata_i;
                resp_valid_q <= grant_oh_q;
            end
            if (expire) begin
                rdata_q      <= '0;
                resp_valid_q <= grant_oh_q;
                timeout_q    <= 1'b1;
            end
        end
    end

    assign bus.mem_valid_o  = (state_q == ISSUE);
    assign bus.mem_we_o     = we_q;
    assign bus.mem_addr_o   = addr_q;
    assign bus.mem_wdata_o  = wdata_q;
    assign bus.req_ready_o  = accept ? grant_oh_q : '0;
    assign bus.resp_valid_o = resp_valid_q;
    assign bus.resp_data_o  = rdata_q;
    assign timeout_o        = timeout_q;
    assign grant_id_o       = grant_id_q;

endmodule

// File: tb/tb_dmem_rr_arbiter.sv
// Scoreboard bench for dmem_rr_arbiter (4 cores, timeout 10).
// Stimulus queues expected accepts/responses; a negedge monitor checks them.
module tb_dmem_rr_arbiter;
    import dmem_rr_arbiter_pkg::*;

    localparam int to_lp = 10;

    typedef struct {
        int      core;
        mem_in_s req;
    } acc_t;

    typedef struct {
        int       core;
        mem_out_s rsp;
        logic     to;
        longint   cyc;
    } rsp_t;

    logic        clk   = 1'b0;
    logic        reset = 1'b1;
    logic        timeout;
    logic [1:0]  grant_id;
    longint      cyc   = 0;
    int          n_chk = 0;
    int          n_fail = 0;
    acc_t        exp_acc[$];
    rsp_t        exp_rsp[$];
    logic [31:0] addr_a  [4];
    logic [31:0] wdata_a [4];
    logic        have_prev = 1'b0;
    logic [64:0] prev, cur;
    acc_t        mea;
    rsp_t        mer;

    dmem_rr_arbiter_if #(
        .num_cores_p(4), .addr_width_p(32), .data_width_p(32)
    ) bus ();

    for (genvar k = 0; k < 4; k++) begin : g_pack
        assign bus.req_addr_i[k*32 +: 32]  = addr_a[k];
        assign bus.req_wdata_i[k*32 +: 32] = wdata_a[k];
    end

    dmem_rr_arbiter #(
        .num_cores_p(4), .addr_width_p(32),
        .data_width_p(32), .timeout_p(to_lp)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .timeout_o (timeout),
        .grant_id_o(grant_id)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [3:0] oh(input int c);
        oh = 4'b0001 << c;
    endfunction

    function automatic int idx_of(input logic [3:0] v);
        idx_of = -1;
        for (int k = 3; k >= 0; k--) if (v[k[1:0]]) idx_of = k;
    endfunction

    task automatic chk(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: field stability while stalled, accepts and responses
    always @(negedge clk) begin
        cur = {bus.mem_we_o, bus.mem_addr_o, bus.mem_wdata_o};
        if (reset) begin
            have_prev = 1'b0;
        end else begin
            if (bus.mem_valid_o) begin
                if (have_prev) chk("hold_fields", 128'(cur), 128'(prev));
                if (bus.mem_ready_i) begin
                    have_prev = 1'b0;
                    if (exp_acc.size() == 0) begin
                        n_chk++;
                        n_fail++;
                        $display("FAIL unexpected_accept: got req_ready 0x%0h, expected none",
                                 bus.req_ready_o);
                    end else begin
                        mea = exp_acc.pop_front();
                        chk("acc_ready", 128'(bus.req_ready_o), 128'(oh(mea.core)));
                        chk("acc_fields", 128'(cur),
                            128'({mea.req.we, mea.req.addr, mea.req.wdata}));
                        chk("acc_grant_id", 128'(grant_id), 128'(mea.core));
                    end
                end else begin
                    have_prev = 1'b1;
                    prev      = cur;
                end
            end else begin
                have_prev = 1'b0;
                chk("ready_idle", 128'(bus.req_ready_o), 128'(0));
            end
            if (bus.resp_valid_o != 4'b0 || timeout) begin
                if (exp_rsp.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_resp: got resp_valid 0x%0h timeout %0b, expected none",
                             bus.resp_valid_o, timeout);
                end else begin
                    mer = exp_rsp.pop_front();
                    chk("rsp_valid", 128'(bus.resp_valid_o), 128'(oh(mer.core)));
                    chk("rsp_data", 128'(bus.resp_data_o), 128'(mer.rsp.rdata));
                    chk("rsp_timeout", 128'(timeout), 128'(mer.to));
                    chk("rsp_cycle", 128'(cyc), 128'(mer.cyc));
                end
            end
        end
    end

    task automatic push_rsp(input int c, input logic [31:0] d,
                            input logic to, input longint at);
        rsp_t r;
        r.core      = c;
        r.rsp.valid = 1'b1;
        r.rsp.rdata = d;
        r.to        = to;
        r.cyc       = at;
        exp_rsp.push_back(r);
    endtask

    task automatic push_acc(input int c, input logic we,
                            input logic [31:0] a, input logic [31:0] d);
        acc_t e;
        e.core      = c;
        e.req.valid = 1'b1;
        e.req.we    = we;
        e.req.addr  = a;
        e.req.wdata = d;
        exp_acc.push_back(e);
    endtask

    task automatic do_req(input int c, input logic we, input logic [31:0] a,
                          input logic [31:0] d, output longint acc_cyc);
        bit ok;
        push_acc(c, we, a, d);
        addr_a[c[1:0]]          = a;
        wdata_a[c[1:0]]         = d;
        bus.req_we_i[c[1:0]]    = we;
        bus.req_valid_i[c[1:0]] = 1'b1;
        ok      = 1'b0;
        acc_cyc = 0;
        for (int i = 0; i < 60 && !ok; i++) begin
            @(negedge clk);
            if (bus.req_ready_o[c[1:0]]) begin
                ok      = 1'b1;
                acc_cyc = cyc;
            end
        end
        if (!ok) begin
            n_chk++;
            n_fail++;
            $display("FAIL accept_wait core %0d: got no req_ready_o in 60 cycles, expected accept", c);
        end
        tick();
        bus.req_valid_i[c[1:0]] = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_mem_valid"}, 128'(bus.mem_valid_o), 128'(0));
        chk({tag, "_mem_fields"},
            128'({bus.mem_we_o, bus.mem_addr_o, bus.mem_wdata_o}), 128'(0));
        chk({tag, "_req_ready"}, 128'(bus.req_ready_o), 128'(0));
        chk({tag, "_resp_valid"}, 128'(bus.resp_valid_o), 128'(0));
        chk({tag, "_resp_data"}, 128'(bus.resp_data_o), 128'(0));
        chk({tag, "_timeout"}, 128'(timeout), 128'(0));
        chk({tag, "_grant_id"}, 128'(grant_id), 128'(0));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_time_limit: got no end of stimulus, expected finish");
        $fatal(1);
    end

    initial begin
        longint a;
        int     g, g_first, nv;
        int     waits [4];
        int     rnd   [4];

        bus.req_valid_i      = '0;
        bus.req_we_i         = '0;
        bus.mem_ready_i      = 1'b1;
        bus.mem_resp_valid_i = 1'b0;
        bus.mem_rdata_i      = '0;
        for (int k = 0; k < 4; k++) begin
            addr_a[k]  = '0;
            wdata_a[k] = '0;
        end

        repeat (3) tick();
        reset = 1'b0;
        @(negedge clk);
        check_zero("reset");
        tick();

        // single write, zero-wait memory
        do_req(2, 1'b1, 32'h40, 32'hDEADBEEF, a);
        @(negedge clk);
        chk("wr_one_cycle", 128'(bus.mem_valid_o), 128'(0));
        chk("wr_no_resp", 128'(bus.resp_valid_o), 128'(0));
        tick();

        // read answered 5 cycles after accept
        do_req(0, 1'b0, 32'h10, 32'h0, a);
        repeat (4) tick();
        push_rsp(0, 32'h12345678, 1'b0, cyc + 1);
        bus.mem_resp_valid_i = 1'b1;
        bus.mem_rdata_i      = 32'h12345678;
        tick();
        bus.mem_resp_valid_i = 1'b0;
        repeat (3) tick();

        // fairness: all four cores stream writes, two rounds each
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        for (int t = 0; t < 8; t++)
            push_acc(t % 4, 1'b1, 32'h200 + (t % 4) * 16 + t / 4,
                     32'hA000_0000 + (t % 4) * 256 + t / 4);
        for (int k = 0; k < 4; k++) begin
            addr_a[k]  = 32'h200 + k * 16;
            wdata_a[k] = 32'hA000_0000 + k * 256;
            waits[k]   = 0;
            rnd[k]     = 0;
        end
        bus.req_we_i    = 4'hF;
        bus.req_valid_i = 4'hF;
        for (int t = 0; t < 8; t++) begin
            g = -1;
            for (int i = 0; i < 20 && g < 0; i++) begin
                @(negedge clk);
                g = idx_of(bus.req_ready_o);
            end
            if (g < 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL rr_accept_wait: got no accept in 20 cycles, expected grant %0d", t % 4);
                break;
            end
            chk("rr_order", 128'(g), 128'(t % 4));
            chk("rr_max_wait", 128'(waits[g] <= 3), 128'(1));
            for (int k = 0; k < 4; k++) waits[k]++;
            waits[g] = 0;
            tick();
            rnd[g]++;
            if (rnd[g] == 2) begin
                bus.req_valid_i[g[1:0]] = 1'b0;
            end else begin
                addr_a[g[1:0]]  = 32'h200 + g * 16 + rnd[g];
                wdata_a[g[1:0]] = 32'hA000_0000 + g * 256 + rnd[g];
            end
        end
        bus.req_valid_i = '0;
        bus.req_we_i    = '0;
        tick();

        // backpressure: memory stalls 7 cycles, accepts on the 8th
        bus.mem_ready_i = 1'b0;
        push_acc(1, 1'b1, 32'h80, 32'hCAFEF00D);
        addr_a[1]          = 32'h80;
        wdata_a[1]         = 32'hCAFEF00D;
        bus.req_we_i[1]    = 1'b1;
        bus.req_valid_i[1] = 1'b1;
        tick();
        nv = 0;
        repeat (7) begin
            @(negedge clk);
            if (bus.mem_valid_o && bus.req_ready_o == 4'b0) nv++;
            tick();
        end
        bus.mem_ready_i = 1'b1;
        @(negedge clk);
        chk("bp_accept", 128'(bus.req_ready_o), 128'(4'b0010));
        chk("bp_stall_cycles", 128'(nv), 128'(7));
        tick();
        bus.req_valid_i[1] = 1'b0;
        bus.req_we_i[1]    = 1'b0;
        tick();

        // timeout, stray late response, then a normal read
        do_req(3, 1'b0, 32'hC0, 32'h0, a);
        push_rsp(3, 32'h0, 1'b1, a + 1 + to_lp);
        repeat (14) tick();
        bus.mem_resp_valid_i = 1'b1;
        bus.mem_rdata_i      = 32'hBAD0BAD0;
        tick();
        bus.mem_resp_valid_i = 1'b0;
        repeat (2) tick();
        do_req(3, 1'b0, 32'hC4, 32'h0, a);
        tick();
        push_rsp(3, 32'h5555AAAA, 1'b0, cyc + 1);
        bus.mem_resp_valid_i = 1'b1;
        bus.mem_rdata_i      = 32'h5555AAAA;
        tick();
        bus.mem_resp_valid_i = 1'b0;
        repeat (3) tick();

        // reset during an outstanding read
        do_req(1, 1'b0, 32'h44, 32'h0, a);
        repeat (2) tick();
        reset = 1'b1;
        tick();
        @(negedge clk);
        check_zero("rst_wait");
        tick();
        reset = 1'b0;
        repeat (3) tick();
        bus.mem_resp_valid_i = 1'b1;
        bus.mem_rdata_i      = 32'h0BADF00D;
        tick();
        bus.mem_resp_valid_i = 1'b0;
        repeat (12) tick();

        // pointer is back at 0: core 1 beats core 3
        push_acc(1, 1'b1, 32'h300, 32'h11111111);
        push_acc(3, 1'b1, 32'h304, 32'h33333333);
        addr_a[1]  = 32'h300;
        wdata_a[1] = 32'h11111111;
        addr_a[3]  = 32'h304;
        wdata_a[3] = 32'h33333333;
        bus.req_we_i    = 4'b1010;
        bus.req_valid_i = 4'b1010;
        g_first = -1;
        for (int n = 0; n < 2; n++) begin
            g = -1;
            for (int i = 0; i < 20 && g < 0; i++) begin
                @(negedge clk);
                g = idx_of(bus.req_ready_o);
            end
            if (g < 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL ptr_accept_wait: got no accept in 20 cycles, expected one");
                break;
            end
            if (n == 0) g_first = g;
            tick();
            bus.req_valid_i[g[1:0]] = 1'b0;
        end
        chk("ptr_reset_first", 128'(g_first), 128'(1));
        bus.req_valid_i = '0;
        bus.req_we_i    = '0;
        repeat (4) tick();

        chk("acc_queue_empty", 128'(exp_acc.size()), 128'(0));
        chk("rsp_queue_empty", 128'(exp_rsp.size()), 128'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
